// File: rtl/csa_accum_ctrl.sv
// Operand accumulator built on one 3:2 carry-save stage. Operands are folded
// into a redundant sum/carry pair, then resolved with a single carry-propagate add.
module csa_accum_ctrl #(
  parameter int DATA_W  = 6,
  parameter int MAX_OPS = 16,
  localparam int CNT_W  = $clog2(MAX_OPS) + 1,
  localparam int ACC_W  = DATA_W + $clog2(MAX_OPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_ops,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t             state;
  logic [ACC_W-1:0]   sum_vec;
  logic [ACC_W-1:0]   carry_vec;
  logic [CNT_W-1:0]   cnt;

  logic [ACC_W-1:0]   z;
  logic [ACC_W-1:0]   csa_sum;
  logic [ACC_W-1:0]   csa_carry;
  logic               num_ok;
  logic               in_hs;

  // 3:2 compressor: the carry MSB dropped by the shift is always 0 given ACC_W.
  always_comb begin
    z         = {{(ACC_W-DATA_W){1'b0}}, in_data};
    csa_sum   = sum_vec ^ carry_vec ^ z;
    csa_carry = ((sum_vec & carry_vec) | (sum_vec & z) | (carry_vec & z)) << 1;
    num_ok    = (num_ops != '0) && (num_ops <= CNT_W'(MAX_OPS));
    in_hs     = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sum_vec   <= '0;
      carry_vec <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_ok) begin
              sum_vec   <= '0;
              carry_vec <= '0;
              cnt       <= num_ops;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
              state     <= ACCUM;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (in_hs) begin
            sum_vec   <= csa_sum;
            carry_vec <= csa_carry;
            cnt       <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              in_ready <= 1'b0;
              state    <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          out_sum   <= sum_vec + carry_vec;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed self-checking bench for csa_accum_ctrl; inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_csa_accum_ctrl;

  localparam int DATA_W  = 6;
  localparam int MAX_OPS = 16;
  localparam int CNT_W   = 5;
  localparam int ACC_W   = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  num_ops = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_sum;
  logic              busy;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  csa_accum_ctrl #(.DATA_W(DATA_W), .MAX_OPS(MAX_OPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start     = 1'($urandom_range(0, 1));
      num_ops   = CNT_W'($urandom_range(0, 31));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = DATA_W'($urandom_range(0, 63));
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if ({in_ready, out_valid, busy, err} !== 4'b0000 || out_sum !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: in_ready=%0b out_valid=%0b busy=%0b err=%0b out_sum=%0d, expected all 0",
                 in_ready, out_valid, busy, err, out_sum);
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; num_ops = '0; in_data = '0;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({in_ready, out_valid, busy, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b busy=%0b err=%0b, expected all 0",
               in_ready, out_valid, busy, err);
    end
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] ops [3];
    ops[0] = 6'd40; ops[1] = 6'd25; ops[2] = 6'd20;
    start = 1'b1; num_ops = 5'd3;
    tick();
    start = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_arm: in_ready=%0b busy=%0b, expected 1 1", in_ready, busy);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = ops[i];
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_resolve: in_ready=%0b out_valid=%0b, expected 0 0", in_ready, out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 10'd85) begin
      n_fail++;
      $display("FAIL basic_result: out_valid=%0b out_sum=%0d, expected 1 85", out_valid, out_sum);
    end
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 10'd85) begin
      n_fail++;
      $display("FAIL basic_idle: out_valid=%0b busy=%0b out_sum=%0d, expected 0 0 85", out_valid, busy, out_sum);
    end
  endtask

  task automatic test_full();
    int hs = 0;
    start = 1'b1; num_ops = 5'd16;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200 && hs < 16; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 6'd63;
      if (in_valid && in_ready) hs++;
      tick();
    end
    n_checks++;
    if (hs != 16) begin
      n_fail++;
      $display("FAIL full_handshakes: got %0d handshakes, expected 16 within budget", hs);
    end
    in_valid = 1'b1; in_data = 6'd63;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready_drop: in_ready=%0b, expected 0", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 10'd1008 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_result: out_valid=%0b out_sum=%0d in_ready=%0b, expected 1 1008 0",
               out_valid, out_sum, in_ready);
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_sum !== 10'd1008) begin
      n_fail++;
      $display("FAIL full_idle: busy=%0b out_sum=%0d, expected 0 1008", busy, out_sum);
    end
  endtask

  task automatic test_err();
    logic [CNT_W-1:0] bad [2];
    bad[0] = 5'd0; bad[1] = 5'd17;
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; num_ops = bad[i];
      tick();
      start = 1'b0;
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL err_pulse_%0d: err=%0b busy=%0b, expected 1 0", bad[i], err, busy);
      end
      tick();
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL err_clear_%0d: err=%0b busy=%0b, expected 0 0", bad[i], err, busy);
      end
    end
    start = 1'b1; num_ops = 5'd1;
    tick();
    start = 1'b0;
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL one_op_arm: err=%0b busy=%0b, expected 0 1", err, busy);
    end
    in_valid = 1'b1; in_data = 6'd0;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 10'd0) begin
      n_fail++;
      $display("FAIL one_op_zero: out_valid=%0b out_sum=%0d, expected 1 0", out_valid, out_sum);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    start = 1'b1; num_ops = 5'd2;
    tick();
    start = 1'b1; num_ops = 5'd3;
    in_valid = 1'b1; in_data = 6'd7;
    tick();
    in_data = 6'd9;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 10'd16 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: out_valid=%0b out_sum=%0d err=%0b, expected 1 16 0",
                 i, out_valid, out_sum, err);
      end
      tick();
    end
    start = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: out_valid=%0b busy=%0b err=%0b, expected 0 0 0", out_valid, busy, err);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || out_sum !== 10'd16) begin
      n_fail++;
      $display("FAIL stall_no_restart: busy=%0b out_sum=%0d, expected 0 16", busy, out_sum);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; num_ops = 5'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 6'd10;
    tick();
    in_data = 6'd20;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_midjob: busy=%0b in_ready=%0b, expected 1 1", busy, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%0b in_ready=%0b out_valid=%0b out_sum=%0d, expected 0 0 0 0",
               busy, in_ready, out_valid, out_sum);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1; num_ops = 5'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 6'd63;
    tick();
    in_data = 6'd1;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 10'd64) begin
      n_fail++;
      $display("FAIL async_new_job: out_valid=%0b out_sum=%0d, expected 1 64", out_valid, out_sum);
    end
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_final_idle: busy=%0b out_valid=%0b, expected 0 0", busy, out_valid);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_full();
    test_err();
    test_stall();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
